// File: rtl/smul_accumulator_pkg.sv
// Shared precision encodings, lane geometry and FSM state encoding for smul_accumulator.
// Pure definitions, no logic; imported by the accumulator and its lane adder.
package smul_accumulator_pkg;

  localparam logic [3:0] PREC_INT8  = 4'b0001;
  localparam logic [3:0] PREC_INT16 = 4'b0010;
  localparam logic [3:0] PREC_INT32 = 4'b0100;
  localparam logic [3:0] PREC_INT64 = 4'b1000;

  localparam int LANES_INT8  = 8;
  localparam int LANES_INT16 = 4;
  localparam int LANES_INT32 = 2;
  localparam int LANES_INT64 = 1;

  localparam int LANE_W_INT8  = 8;
  localparam int LANE_W_INT16 = 16;
  localparam int LANE_W_INT32 = 32;
  localparam int LANE_W_INT64 = 64;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  // Isolate the lowest set bit so a multi-hot select resolves to the narrowest precision.
  function automatic logic [3:0] prec_decode(input logic [3:0] sel);
    return sel & (~sel + 4'd1);
  endfunction

  function automatic logic [63:0] prec_msb_mask(input logic [3:0] prec);
    case (prec)
      PREC_INT8:  return 64'h8080_8080_8080_8080;
      PREC_INT16: return 64'h8000_8000_8000_8000;
      PREC_INT32: return 64'h8000_0000_8000_0000;
      PREC_INT64: return 64'h8000_0000_0000_0000;
      default:    return 64'h0;
    endcase
  endfunction

endpackage

// File: rtl/smul_lane_adder.sv
// Lane-segmented 64-bit adder: carries never cross lane boundaries, signed overflow per lane.
// Purely combinational; no flow control.
module smul_lane_adder
  import smul_accumulator_pkg::*;
(
  input  logic [63:0] i_a,
  input  logic [63:0] i_b,
  input  logic [3:0]  i_prec,
  output logic [63:0] o_sum,
  output logic [7:0]  o_ovf
);

  logic [63:0]            w_msb;
  logic [63:0]            w_low_sum;
  logic [7:0]             w_byte_ovf;
  logic [LANES_INT8-1:0]  w_ovf8;
  logic [LANES_INT16-1:0] w_ovf16;
  logic [LANES_INT32-1:0] w_ovf32;
  logic [LANES_INT64-1:0] w_ovf64;

  // Adding with lane MSBs masked off cannot carry out of a lane; the MSB is then rebuilt by XOR.
  assign w_msb     = prec_msb_mask(i_prec);
  assign w_low_sum = (i_a & ~w_msb) + (i_b & ~w_msb);
  assign o_sum     = w_low_sum ^ ((i_a ^ i_b) & w_msb);

  for (genvar k = 0; k < 8; k++) begin : g_byte
    assign w_byte_ovf[k] = ~(i_a[8*k+7] ^ i_b[8*k+7]) & (i_a[8*k+7] ^ o_sum[8*k+7]);
  end

  for (genvar l = 0; l < LANES_INT8; l++) begin : g_ovf8
    assign w_ovf8[l] = w_byte_ovf[(l+1)*(LANE_W_INT8/8)-1];
  end
  for (genvar l = 0; l < LANES_INT16; l++) begin : g_ovf16
    assign w_ovf16[l] = w_byte_ovf[(l+1)*(LANE_W_INT16/8)-1];
  end
  for (genvar l = 0; l < LANES_INT32; l++) begin : g_ovf32
    assign w_ovf32[l] = w_byte_ovf[(l+1)*(LANE_W_INT32/8)-1];
  end
  for (genvar l = 0; l < LANES_INT64; l++) begin : g_ovf64
    assign w_ovf64[l] = w_byte_ovf[(l+1)*(LANE_W_INT64/8)-1];
  end

  always_comb begin
    o_ovf = 8'd0;
    case (i_prec)
      PREC_INT8:  o_ovf = w_ovf8;
      PREC_INT16: o_ovf = {4'd0, w_ovf16};
      PREC_INT32: o_ovf = {6'd0, w_ovf32};
      PREC_INT64: o_ovf = {7'd0, w_ovf64};
      default:    o_ovf = 8'd0;
    endcase
  end

endmodule

// File: rtl/smul_accumulator.sv
// Issues operand beats to the sub-MAC multiplier and accumulates returned products lane-wise.
// Result valid len+MUL_LATENCY cycles after the first issue; held stable in HOLD until out_ready.
module smul_accumulator
  import smul_accumulator_pkg::*;
#(
  parameter int MUL_LATENCY = 3,
  parameter int LEN_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] acc_len,
  input  logic [3:0]       prec_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             mul_ce,
  input  logic [63:0]      prod,
  output logic [63:0]      out_data,
  output logic [7:0]       out_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  logic [1:0]             r_state;
  logic [LEN_W-1:0]       r_len;
  logic [LEN_W-1:0]       r_issue_cnt;
  logic [LEN_W-1:0]       r_recv_cnt;
  logic [3:0]             r_prec;
  logic [MUL_LATENCY-1:0] r_vld_pipe;
  logic [63:0]            r_acc;
  logic [7:0]             r_ovf;

  logic             w_prod_vld;
  logic             w_acc_en;
  logic             w_start_ok;
  logic             w_drain_done;
  logic [LEN_W-1:0] w_recv_nxt;
  logic [63:0]      w_sum;
  logic [7:0]       w_ovf;

  assign in_ready     = (r_state == S_ACCUM) && (r_issue_cnt < r_len);
  assign mul_ce       = in_valid & in_ready;
  assign w_prod_vld   = r_vld_pipe[MUL_LATENCY-1];
  assign w_acc_en     = w_prod_vld && ((r_state == S_ACCUM) || (r_state == S_DRAIN));
  assign w_start_ok   = start && (prec_sel != 4'd0) && (acc_len != '0);
  assign w_recv_nxt   = r_recv_cnt + LEN_W'(1);
  // Leave DRAIN in the same cycle the last product lands so HOLD follows immediately.
  assign w_drain_done = (r_recv_cnt == r_len) || (w_acc_en && (w_recv_nxt == r_len));

  assign out_valid = (r_state == S_HOLD);
  assign busy      = (r_state != S_IDLE);
  assign out_data  = r_acc;
  assign out_ovf   = r_ovf;

  smul_lane_adder u_lane_adder (
    .i_a    (r_acc),
    .i_b    (prod),
    .i_prec (r_prec),
    .o_sum  (w_sum),
    .o_ovf  (w_ovf)
  );

  if (MUL_LATENCY == 1) begin : g_pipe1
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_vld_pipe <= '0;
      else        r_vld_pipe <= mul_ce;
    end
  end else begin : g_pipen
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_vld_pipe <= '0;
      else        r_vld_pipe <= {r_vld_pipe[MUL_LATENCY-2:0], mul_ce};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_len       <= '0;
      r_issue_cnt <= '0;
      r_recv_cnt  <= '0;
      r_prec      <= 4'd0;
      r_acc       <= 64'd0;
      r_ovf       <= 8'd0;
    end else begin
      if (w_acc_en) begin
        r_acc      <= w_sum;
        r_ovf      <= r_ovf | w_ovf;
        r_recv_cnt <= w_recv_nxt;
      end
      case (r_state)
        S_IDLE: begin
          if (w_start_ok) begin
            r_len       <= acc_len;
            r_prec      <= prec_decode(prec_sel);
            r_issue_cnt <= '0;
            r_recv_cnt  <= '0;
            r_state     <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (mul_ce) r_issue_cnt <= r_issue_cnt + LEN_W'(1);
          if (r_issue_cnt == r_len) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (w_drain_done) r_state <= S_HOLD;
        end
        S_HOLD: begin
          if (out_ready) begin
            r_acc   <= 64'd0;
            r_ovf   <= 8'd0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_smul_accumulator.sv
// Scoreboard bench for smul_accumulator with a behavioural fixed-latency multiplier.
// Expected results are computed per lane when a batch is loaded and compared on acceptance.
module tb_smul_accumulator;

  localparam int MUL_LATENCY = 3;
  localparam int LEN_W       = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [LEN_W-1:0] acc_len = '0;
  logic [3:0]       prec_sel = 4'd0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             mul_ce;
  logic [63:0]      prod = 64'd0;
  logic [63:0]      out_data;
  logic [7:0]       out_ovf;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic             busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int first_issue_cyc = -1;
  int valid_cyc = -1;

  logic [63:0] bq[$];
  logic [63:0] prod_q[$];
  logic [63:0] exp_d[$];
  logic [7:0]  exp_o[$];
  logic [15:0] ce_hist = 16'd0;

  smul_accumulator #(.MUL_LATENCY(MUL_LATENCY), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .acc_len   (acc_len),
    .prec_sel  (prec_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mul_ce    (mul_ce),
    .prod      (prod),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Multiplier model: product for an issue appears MUL_LATENCY cycles later, garbage otherwise.
  always @(negedge clk) begin
    if (!rst_n) begin
      ce_hist = 16'd0;
      prod_q.delete();
      prod = 64'd0;
    end else begin
      ce_hist = {ce_hist[14:0], mul_ce};
      if (ce_hist[MUL_LATENCY]) prod = (prod_q.size() > 0) ? prod_q.pop_front() : 64'd0;
      else prod = 64'hDEAD_BEEF_DEAD_BEEF;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (mul_ce && first_issue_cyc < 0) first_issue_cyc = cyc;
      if (out_valid && valid_cyc < 0) valid_cyc = cyc;
      if (out_valid && out_ready) begin
        check_val("sb_nonempty", 64'(exp_d.size() != 0), 64'd1);
        if (exp_d.size() != 0) begin
          check_val("out_data", out_data, exp_d.pop_front());
          check_val("out_ovf", 64'(out_ovf), 64'(exp_o.pop_front()));
        end
      end
    end
  end

  // Queue the products in bq for the multiplier and push the lane-wise expected result.
  task automatic load_batch(input logic [3:0] psel);
    logic [63:0] d, a, p, s, mask;
    logic [7:0]  o;
    int w;
    w = 0;
    for (int b = 0; b < 4; b++) if (psel[b] && w == 0) w = 8 << b;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    d = 64'd0;
    o = 8'd0;
    foreach (bq[i]) begin
      prod_q.push_back(bq[i]);
      for (int l = 0; l < 64 / w; l++) begin
        a = (d >> (l * w)) & mask;
        p = (bq[i] >> (l * w)) & mask;
        s = (a + p) & mask;
        if ((a[w-1] == p[w-1]) && (s[w-1] != a[w-1])) o[l] = 1'b1;
        d = (d & ~(mask << (l * w))) | (s << (l * w));
      end
    end
    exp_d.push_back(d);
    exp_o.push_back(o);
  endtask

  task automatic do_start(input int len, input logic [3:0] psel);
    start    = 1'b1;
    acc_len  = LEN_W'(len);
    prec_sel = psel;
    tick();
    start = 1'b0;
  endtask

  task automatic issue(input string tag, input int len, input logic [7:0] pat, input int plen);
    int n = 0;
    int k = 0;
    while (n < len && k < 200) begin
      in_valid = pat[3'(k % plen)];
      if (in_valid && in_ready) n++;
      tick();
      k++;
    end
    in_valid = 1'b0;
    check_val(tag, 64'(n), 64'(len));
  endtask

  task automatic wait_valid(input string tag);
    int k = 0;
    while (!out_valid && k < 100) begin
      tick();
      k++;
    end
    check_val(tag, 64'(out_valid), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_in_ready", 64'(in_ready), 64'd0);
    check_val("rst_out_valid", 64'(out_valid), 64'd0);
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_out_data", out_data, 64'd0);
    check_val("rst_out_ovf", 64'(out_ovf), 64'd0);
    rst_n = 1'b1;
    tick();

    // INT8 continuous issue, latency measured inclusive of the first issue cycle
    bq.delete();
    repeat (4) bq.push_back(64'h0102_0304_0506_0708);
    load_batch(4'b0001);
    first_issue_cyc = -1;
    valid_cyc = -1;
    in_valid = 1'b1;
    do_start(4, 4'b0001);
    issue("t1_issued", 4, 8'h01, 1);
    wait_valid("t1_valid");
    check_val("t1_data_const", out_data, 64'h0408_0C10_1418_1C20);
    @(negedge clk);
    #1;
    check_val("t1_latency", 64'(valid_cyc - first_issue_cyc + 1), 64'(MUL_LATENCY + 5));
    tick();
    check_val("t1_idle", 64'(busy), 64'd0);

    // INT16 with lane 3 overflow
    bq.delete();
    bq.push_back(64'h7FFF_0000_0001_0001);
    bq.push_back(64'h0001_FFFF_0001_0001);
    load_batch(4'b0010);
    in_valid = 1'b1;
    do_start(2, 4'b0010);
    issue("t2_issued", 2, 8'h01, 1);
    wait_valid("t2_valid");
    check_val("t2_data_const", out_data, 64'h8000_FFFF_0002_0002);
    check_val("t2_ovf_const", 64'(out_ovf), 64'h08);
    tick();

    // INT32 with gapped issue and a stalled consumer
    bq.delete();
    bq.push_back(64'h0000_0001_7FFF_FFFF);
    bq.push_back(64'h0000_0002_0000_0001);
    bq.push_back(64'hFFFF_FFFF_0000_0003);
    load_batch(4'b0100);
    out_ready = 1'b0;
    do_start(3, 4'b0100);
    issue("t3_issued", 3, 8'b0001_0101, 5);
    check_val("t3_in_ready_drop", 64'(in_ready), 64'd0);
    wait_valid("t3_valid");
    for (int i = 0; i < 5; i++) begin
      check_val("t3_hold_data", out_data, exp_d[0]);
      check_val("t3_hold_ovf", 64'(out_ovf), 64'(exp_o[0]));
      tick();
    end
    out_ready = 1'b1;
    tick();
    check_val("t3_idle_busy", 64'(busy), 64'd0);
    check_val("t3_idle_valid", 64'(out_valid), 64'd0);

    // Illegal starts, then a start pulse while accumulating
    in_valid = 1'b1;
    do_start(0, 4'b0001);
    for (int i = 0; i < 3; i++) begin
      check_val("t4_len0_busy", 64'(busy), 64'd0);
      check_val("t4_len0_ce", 64'(mul_ce), 64'd0);
      tick();
    end
    do_start(4, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      check_val("t4_prec0_busy", 64'(busy), 64'd0);
      check_val("t4_prec0_ce", 64'(mul_ce), 64'd0);
      tick();
    end
    in_valid = 1'b0;
    bq.delete();
    bq.push_back(64'h1111_1111_1111_1111);
    bq.push_back(64'h2222_2222_7070_7070);
    load_batch(4'b0001);
    do_start(2, 4'b0001);
    do_start(5, 4'b1000);
    issue("t4_issued", 2, 8'h01, 1);
    check_val("t4_len_kept", 64'(in_ready), 64'd0);
    wait_valid("t4_valid");
    tick();

    // INT64 interrupted by reset with products in flight
    bq.delete();
    for (int i = 1; i <= 8; i++) bq.push_back(64'h0100_0000_0000_0003 * 64'(i));
    load_batch(4'b1000);
    in_valid = 1'b1;
    do_start(8, 4'b1000);
    issue("t5_issued", 5, 8'h01, 1);
    rst_n = 1'b0;
    #1;
    check_val("t5_rst_busy", 64'(busy), 64'd0);
    check_val("t5_rst_in_ready", 64'(in_ready), 64'd0);
    check_val("t5_rst_valid", 64'(out_valid), 64'd0);
    check_val("t5_rst_data", out_data, 64'd0);
    check_val("t5_rst_ovf", 64'(out_ovf), 64'd0);
    check_val("t5_rst_ce", 64'(mul_ce), 64'd0);
    exp_d.delete();
    exp_o.delete();
    tick();
    rst_n = 1'b1;
    tick();
    bq.delete();
    bq.push_back(64'd5);
    load_batch(4'b1000);
    in_valid = 1'b1;
    do_start(1, 4'b1000);
    issue("t5_new_issued", 1, 8'h01, 1);
    wait_valid("t5_new_valid");
    check_val("t5_new_data", out_data, 64'd5);
    tick();

    // Multi-hot select resolves to INT16
    bq.delete();
    repeat (2) bq.push_back(64'hFFFF_FFFF_FFFF_FFFF);
    load_batch(4'b0010);
    in_valid = 1'b1;
    do_start(2, 4'b0110);
    issue("t6_issued", 2, 8'h01, 1);
    wait_valid("t6_valid");
    check_val("t6_data_const", out_data, 64'hFFFE_FFFE_FFFE_FFFE);
    tick();

    check_val("sb_drained", 64'(exp_d.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/smul_accumulator.md
Name: smul_accumulator

Overview:
- Consumer side of the sub-MAC multiplier: issues operand beats, then collects the packed 64-bit product word a fixed number of cycles later.
- Accumulates each product lane-wise, by precision, over a programmable number of beats.
- Presents the accumulated word with per-lane overflow flags on a valid/ready output toward the result writeback path.
- Sits between the operand scheduler and the multiplier's res_mac_next output.

Parameters:
- MUL_LATENCY, 3: cycles from an issue beat (mul_ce high) to the matching product on prod; must be ≥1.
- LEN_W, 16: width of the batch-length field.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a batch (sampled in IDLE only)
- acc_len  in  LEN_W  number of products in the batch; latched on start
- prec_sel  in  4  one-hot precision, latched on start:
  - bit0 = INT8, 8 lanes of 8b
  - bit1 = INT16, 4 lanes of 16b
  - bit2 = INT32, 2 lanes of 32b
  - bit3 = INT64, 1 lane of 64b
- in_valid  in  1  scheduler has an operand beat for the multiplier
- in_ready  out  1  beat accepted this cycle when in_valid & in_ready
- mul_ce  out  1  multiplier clock enable, equal to in_valid & in_ready (combinational)
- prod  in  64  packed product word from the multiplier
- out_data  out  64  accumulated lanes
- out_ovf  out  8  sticky signed-overflow flag per lane; unused lanes read 0
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts the result
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all accumulators, out_ovf, counters and the valid delay line cleared.
  - in_ready=0, out_valid=0, busy=0, out_data=0.
  - In-flight products are discarded, never accumulated.
- Product valid: a MUL_LATENCY-deep shift register of mul_ce gives prod_vld. prod is sampled only when prod_vld=1.
- Latched precision:
  - prec_sel is decoded at start; the lowest set bit wins.
  - prec_sel=0 or acc_len=0 at start: start ignored, state stays IDLE.
- State IDLE:
  - in_ready=0.
  - start with a legal acc_len and prec_sel: latch both, clear issue_cnt and recv_cnt → ACCUM.
  - start is ignored in every other state.
- State ACCUM:
  - in_ready=1 while issue_cnt < len.
  - Each accepted beat increments issue_cnt.
  - Cycle after issue_cnt reaches len: in_ready=0 → DRAIN. The transition is taken even if every product has already returned.
- Accumulation (applies in ACCUM and DRAIN):
  - Each prod_vld cycle: acc[lane] ← acc[lane] + prod[lane], wrapping modulo lane width (two's complement); recv_cnt increments.
  - Overflow: both operands have the same sign and the sum's sign differs → set out_ovf[lane]. The flag stays set until the batch is accepted.
  - A product arrival in the same cycle as the final issue is legal and is accumulated.
- State DRAIN:
  - in_ready=0.
  - When recv_cnt == len (including the cycle the final product is accumulated, registered next cycle) → HOLD.
- State HOLD:
  - out_valid=1; out_data and out_ovf are stable while out_valid & !out_ready.
  - out_ready high → accumulators and flags clear, out_valid=0 → IDLE.
  - Earliest next start: the cycle after acceptance.
- Latency:
  - First issue to out_valid = len + MUL_LATENCY + 1 cycles with continuous in_valid.
  - For len=1: issue at cycle t, product at t+MUL_LATENCY, out_valid at t+MUL_LATENCY+1.
- Lane packing: lane k occupies bits [k*W+W-1 : k*W] for W = 8/16/32/64. No carries cross lane boundaries.
- Reset asserted mid-batch: immediate return to IDLE. Products returning after reset release are ignored because the delay line was cleared.

Decomposition:
- Shared package / precision_def.vh holds:
  - precision one-hot constants PREC_INT8/16/32/64
  - lane-count and lane-width per precision
  - state encoding IDLE/ACCUM/DRAIN/HOLD
- One sub-module, smul_lane_adder: 64-bit lane-segmented adder with a precision input, per-lane carry kill and per-lane overflow output. It is instantiated once.
- The FSM, counters and delay line stay in the top module.

Test Plan:
1. INT8, len=4, in_valid held, prod=0x0102030405060708 on every prod_vld → out_data=0x04080C1014181C20, out_ovf=0, out_valid exactly MUL_LATENCY+5 cycles after the first issue.
2. INT16, len=2, prod=0x7FFF0000_00010001 then 0x0001FFFF_00010001 → out_data=0x8000FFFF_00020002, out_ovf=0x08 (lane 3 only).
3. INT32, len=3, in_valid toggling 1,0,1,0,1 and out_ready held low for 5 cycles → in_ready drops after the 3rd beat; out_data/out_ovf stable during HOLD; return to IDLE the cycle after out_ready.
4. Start with acc_len=0, then with prec_sel=0 → busy stays 0, mul_ce never asserts. Start pulsed during ACCUM → no effect on len or count.
5. INT64, len=8, rst_n pulsed low after the 5th issue with products in flight → all outputs 0 immediately. A new batch (len=1, prod=5) then yields out_data=5 with no residue.
6. prec_sel=4'b0110 → INT16 decode (lowest set bit). prod=0xFFFF per lane summed twice → each lane 0xFFFE, no carry into the next lane.
